fetch_unit: RTL and testbench

Instruction fetch and program-counter stage of the RV32I single-cycle core. Holds the architectural PC, fetches the instruction at PC over a valid/ready port to instruction memory, and presents it to decode/execute. On retire it commits the next PC: PC+4, or the ALU-computed target when the branch unit's NextPCSrc is high. It sits directly downstream of branch_unit, consuming NextPCSrc, and traps on a misaligned target.

---
 rtl/fetch_unit.sv | 58 +++++
 tb/tb_fetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I program counter and instruction fetch over a valid/ready imem port
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        NextPCSrc,
   input  logic [31:0] ALURes,
   input  logic        Retire,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] PC4,
   output logic [31:0] Inst,
   output logic        InstValid,
   output logic        Misaligned
);
   typedef enum logic [1:0] {FETCH, EXEC, TRAP} state_t;
   state_t state, state_n;
   logic [31:0] pc_n, inst_n, target;
   logic valid_n, mis_n, fire, ret;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= FETCH;
         PC         <= RESET_PC;
         Inst       <= NOP;
         InstValid  <= 1'b0;
         Misaligned <= 1'b0;
      end else begin
         state      <= state_n;
         PC         <= pc_n;
         Inst       <= inst_n;
         InstValid  <= valid_n;
         Misaligned <= mis_n;
      end

   // bit 0 of a jump target is dropped (JALR); a set bit 1 traps instead of redirecting
   always_comb begin
      target  = NextPCSrc ? {ALURes[31:1], 1'b0} : PC4;
      fire    = state == FETCH && imem_ready;
      ret     = state == EXEC && Retire;
      state_n = fire ? EXEC : ret ? (target[1] ? TRAP : FETCH) : state;
      pc_n    = ret && !target[1] ? target : PC;
      inst_n  = fire ? imem_rdata : ret ? NOP : Inst;
      valid_n = fire ? 1'b1 : ret ? 1'b0 : InstValid;
      mis_n   = Misaligned | (ret && target[1]);
   end

   always_comb begin
      imem_req  = state == FETCH && !rst;
      imem_addr = PC;
      PC4       = PC + 32'd4;
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against an instruction-level model
module tb_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk = 0, rst = 0;
   logic        NextPCSrc = 0, Retire = 0, imem_ready = 0;
   logic [31:0] ALURes = 0, imem_rdata = 0;
   logic        imem_req, InstValid, Misaligned;
   logic [31:0] imem_addr, PC, PC4, Inst;
   int total = 0, bad = 0;
   logic [31:0] m_pc, m_inst;
   logic        m_fetching, m_trapped, m_valid, m_mis;

   fetch_unit dut (
      .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .ALURes(ALURes), .Retire(Retire),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .PC(PC), .PC4(PC4), .Inst(Inst),
      .InstValid(InstValid), .Misaligned(Misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_fetching && !m_trapped && !rst});
      chk("imem_addr", imem_addr, m_pc);
      chk("PC", PC, m_pc);
      chk("PC4", PC4, m_pc + 32'd4);
      chk("Inst", Inst, m_inst);
      chk("InstValid", {31'b0, InstValid}, {31'b0, m_valid});
      chk("Misaligned", {31'b0, Misaligned}, {31'b0, m_mis});
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_inst = NOP; m_valid = 0; m_mis = 0;
      m_fetching = 1; m_trapped = 0;
   endtask

   // one instruction at a time: fetch it, then either retire to the next address or trap
   task automatic cycle(input logic rdy, input logic [31:0] rd, input logic ret,
                        input logic nps, input logic [31:0] alu);
      logic [31:0] tgt;
      imem_ready = rdy; imem_rdata = rd; Retire = ret; NextPCSrc = nps; ALURes = alu;
      @(posedge clk);
      if (!m_trapped) begin
         if (m_fetching) begin
            if (rdy) begin m_inst = rd; m_valid = 1; m_fetching = 0; end
         end else if (ret) begin
            tgt = nps ? alu & ~32'd1 : m_pc + 32'd4;
            m_inst = NOP; m_valid = 0;
            if (tgt % 4 != 0) begin m_trapped = 1; m_mis = 1; end
            else begin m_pc = tgt; m_fetching = 1; end
         end
      end
      #1 check_all();
   endtask

   task automatic do_reset(input int n);
      rst = 1;
      model_reset();
      #1 check_all();
      repeat (n) @(posedge clk);
      #1 rst = 0;
      #1 check_all();
   endtask

   initial begin
      logic [31:0] a;
      model_reset();
      #1 do_reset(3);
      repeat (6) cycle(1, $urandom(), 1, 0, 0);
      repeat (4) cycle(1, $urandom(), 1, 0, 0);
      repeat (6) cycle(1, $urandom(), 1, 0, 0);
      repeat (3) cycle(0, $urandom(), 1, 1, $urandom());
      cycle(1, 32'hDEAD_BEEF, 0, 0, 0);
      repeat (3) cycle(1, $urandom(), 0, 1, 32'h0000_0002);
      cycle(0, 0, 1, 1, 32'h0000_0100);
      cycle(1, $urandom(), 1, 1, 32'h0000_0201);
      cycle(1, $urandom(), 1, 1, 32'h0000_0201);
      cycle(1, $urandom(), 1, 1, 32'h0000_0040);
      cycle(1, $urandom(), 1, 1, 32'h0000_0040);
      cycle(1, $urandom(), 0, 0, 0);
      cycle(1, $urandom(), 1, 1, 32'h0000_0102);
      repeat (20) cycle($urandom(), $urandom(), $urandom(), $urandom(), $urandom());
      do_reset(1);
      cycle(1, $urandom(), 0, 0, 0);
      cycle(0, 0, 1, 1, 32'hFFFF_FFFC);
      cycle(1, $urandom(), 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      do_reset(2);
      for (int i = 0; i < 400; i++) begin
         a = $urandom();
         if ($urandom_range(0, 7) != 0) a[1] = 1'b0;
         cycle($urandom(), $urandom(), $urandom(), $urandom(), a);
         if (m_trapped && $urandom_range(0, 5) == 0) do_reset($urandom_range(1, 3));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
